// File: rtl/led_frame_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_frame_sched_if : control, colour-RAM read and tx-shifter signals of
//                      the LED frame sequencer.                  Rev 1.0
// ---------------------------------------------------------------------------
interface led_frame_sched_if #(
  parameter int ADDR_W = 4
);
  logic              enable;
  logic              start;
  logic [4:0]        brightness;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [23:0]       ram_data;
  logic              tx_req;
  logic [31:0]       tx_data;
  logic              tx_busy;
  logic              frame_busy;
  logic              frame_done;

  modport master (
    input  enable, start, brightness, ram_data, tx_busy,
    output ram_re, ram_addr, tx_req, tx_data, frame_busy, frame_done
  );

  modport slave (
    output enable, start, brightness, ram_data, tx_busy,
    input  ram_re, ram_addr, tx_req, tx_data, frame_busy, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/led_frame_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_frame_sched : SK9822 frame sequencer - start word, one brightness+colour
//                   word per LED from RAM, end words; single-shot or periodic.
//                                                                  Rev 1.0
// ---------------------------------------------------------------------------
module led_frame_sched #(
  parameter int N_LEDS     = 12,
  parameter int ADDR_W     = 4,
  parameter int END_WORDS  = 1,
  parameter int GAP_CYCLES = 4096
) (
  input  wire logic         ck,
  input  wire logic         rst_n,
  led_frame_sched_if.master bus
);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int END_B = (END_WORDS > 1) ? $clog2(END_WORDS) : 1;
  localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(N_LEDS - 1);
  localparam logic [END_B-1:0]  c_LAST_END = END_B'(END_WORDS - 1);
  localparam logic [GAP_W-1:0]  c_GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START_W, S_FETCH, S_CAPTURE, S_ISSUE, S_DRAIN, S_END_W
  } state_t;

  // Which kind of word is currently in flight; DRAIN uses it to pick the next.
  typedef enum logic [1:0] {K_START, K_LED, K_END} kind_t;

  state_t            r_state, w_state;
  kind_t             r_kind, w_kind;
  logic [ADDR_W-1:0] r_idx, w_idx;
  logic [END_B-1:0]  r_end_cnt, w_end_cnt;
  logic [4:0]        r_bri, w_bri;
  logic              r_pend, w_pend;
  logic [GAP_W-1:0]  r_gap, w_gap;
  logic              r_ram_re, w_ram_re;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
  logic              r_tx_req, w_tx_req;
  logic [31:0]       r_tx_data, w_tx_data;
  logic              r_frame_busy, w_frame_busy;
  logic              r_frame_done, w_frame_done;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_kind       <= K_START;
      r_idx        <= '0;
      r_end_cnt    <= '0;
      r_bri        <= '0;
      r_pend       <= 1'b0;
      r_gap        <= '0;
      r_ram_re     <= 1'b0;
      r_ram_addr   <= '0;
      r_tx_req     <= 1'b0;
      r_tx_data    <= '0;
      r_frame_busy <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_kind       <= w_kind;
      r_idx        <= w_idx;
      r_end_cnt    <= w_end_cnt;
      r_bri        <= w_bri;
      r_pend       <= w_pend;
      r_gap        <= w_gap;
      r_ram_re     <= w_ram_re;
      r_ram_addr   <= w_ram_addr;
      r_tx_req     <= w_tx_req;
      r_tx_data    <= w_tx_data;
      r_frame_busy <= w_frame_busy;
      r_frame_done <= w_frame_done;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_kind       = r_kind;
    w_idx        = r_idx;
    w_end_cnt    = r_end_cnt;
    w_bri        = r_bri;
    w_pend       = r_pend | (r_frame_busy & bus.start);
    w_gap        = r_gap;
    w_tx_req     = 1'b0;
    w_tx_data    = r_tx_data;
    w_frame_busy = r_frame_busy;
    w_frame_done = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_pend || bus.start || (bus.enable && (r_gap == '0))) begin
          w_state      = S_START_W;
          w_kind       = K_START;
          w_bri        = bus.brightness;
          w_idx        = '0;
          w_pend       = 1'b0;
          w_frame_busy = 1'b1;
        end else if (r_gap != '0) begin
          w_gap = r_gap - GAP_W'(1);
        end
      end
      S_START_W: begin
        w_tx_data = 32'h0000_0000;
        w_tx_req  = 1'b1;
        w_state   = S_ISSUE;
      end
      S_FETCH: w_state = S_CAPTURE;
      S_CAPTURE: begin
        w_tx_data = {3'b111, r_bri, bus.ram_data};
        w_tx_req  = 1'b1;
        w_state   = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.tx_busy) w_state  = S_DRAIN;
        else             w_tx_req = 1'b1;
      end
      S_DRAIN: begin
        if (!bus.tx_busy) begin
          case (r_kind)
            K_START: begin
              w_kind  = K_LED;
              w_state = S_FETCH;
            end
            K_LED: begin
              if (r_idx != c_LAST_IDX) begin
                w_idx   = r_idx + ADDR_W'(1);
                w_state = S_FETCH;
              end else begin
                w_kind    = K_END;
                w_end_cnt = '0;
                w_state   = S_END_W;
              end
            end
            default: begin
              if (r_end_cnt != c_LAST_END) begin
                w_end_cnt = r_end_cnt + END_B'(1);
                w_state   = S_END_W;
              end else begin
                w_state      = S_IDLE;
                w_frame_done = 1'b1;
                w_frame_busy = 1'b0;
                w_gap        = c_GAP_LOAD;
              end
            end
          endcase
        end
      end
      S_END_W: begin
        w_tx_data = 32'hFFFF_FFFF;
        w_tx_req  = 1'b1;
        w_state   = S_ISSUE;
      end
      default: w_state = S_IDLE;
    endcase

    // Strobe and address are registered so they line up with the FETCH cycle.
    w_ram_re   = (w_state == S_FETCH);
    w_ram_addr = w_ram_re ? w_idx : '0;
  end

  assign bus.ram_re     = r_ram_re;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.tx_req     = r_tx_req;
  assign bus.tx_data    = r_tx_data;
  assign bus.frame_busy = r_frame_busy;
  assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_led_frame_sched.sv
`default_nettype none
// tb_led_frame_sched : randomized bench; expected words come from a per-frame
// word-list model built from the RAM image and the brightness at frame start.
module tb_led_frame_sched;
  localparam int N_LEDS     = 3;
  localparam int ADDR_W     = 4;
  localparam int END_WORDS  = 2;
  localparam int GAP_CYCLES = 16;

  logic ck    = 1'b0;
  logic rst_n = 1'b0;
  always #5 ck = ~ck;

  led_frame_sched_if #(.ADDR_W(ADDR_W)) bus ();

  led_frame_sched #(
    .N_LEDS(N_LEDS), .ADDR_W(ADDR_W), .END_WORDS(END_WORDS), .GAP_CYCLES(GAP_CYCLES)
  ) u_dut (
    .ck(ck), .rst_n(rst_n), .bus(bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [23:0] mem [16];
  logic [31:0] exp_q [$];
  logic [31:0] rx_log [$];
  int          frames_started = 0, frames_done = 0;
  int          rise_cyc = 0, done_cyc = 0, rise_gap = 0, led_cnt = 0;
  int          tx_delay = 1;
  logic [4:0]  bri_at_edge;
  logic [31:0] lit [6] = '{32'h0000_0000, 32'hE400_00FF, 32'hE400_FF00,
                           32'hE4FF_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Brightness as the DUT sampled it on the most recent edge.
  always @(posedge ck) bri_at_edge <= bus.brightness;

  // RAM, tx shifter and scoreboard, evaluated 1 time unit after each edge.
  initial begin : env
    logic              fb_d;
    logic              re_d;
    logic [ADDR_W-1:0] addr_d;
    int                tx_st, tx_cnt;
    logic [31:0]       cur_word;
    fb_d = 1'b0; re_d = 1'b0; addr_d = '0; tx_st = 0; tx_cnt = 0; cur_word = '0;
    bus.tx_busy  = 1'b0;
    bus.ram_data = '0;
    forever begin
      @(posedge ck); #1;
      cyc++;
      if (!rst_n) begin
        fb_d = 1'b0; re_d = 1'b0; tx_st = 0; bus.tx_busy = 1'b0;
        exp_q.delete();
        continue;
      end
      if (re_d) bus.ram_data = mem[addr_d];
      re_d   = bus.ram_re;
      addr_d = bus.ram_addr;

      if (bus.frame_busy && !fb_d) begin
        chk("words_left_at_start", exp_q.size(), 0);
        exp_q.delete();
        exp_q.push_back(32'h0000_0000);
        for (int i = 0; i < N_LEDS; i++) exp_q.push_back({3'b111, bri_at_edge, mem[i]});
        for (int i = 0; i < END_WORDS; i++) exp_q.push_back(32'hFFFF_FFFF);
        frames_started++;
        rise_gap = cyc - done_cyc;
        rise_cyc = cyc;
        led_cnt  = 0;
      end
      if (fb_d && !bus.frame_busy) chk("busy_fall_with_done", bus.frame_done, 1);
      if (bus.frame_done) begin
        chk("done_at_busy_fall", {fb_d, bus.frame_busy}, 2'b10);
        chk("words_left_at_done", exp_q.size(), 0);
        chk("leds_fetched", led_cnt, N_LEDS);
        frames_done++;
        done_cyc = cyc;
      end
      if (bus.ram_re) begin
        chk("ram_addr", bus.ram_addr, led_cnt);
        chk("ram_re_in_frame", bus.frame_busy, 1);
        led_cnt++;
      end else begin
        chk("ram_addr_outside_fetch", bus.ram_addr, 0);
      end

      if (tx_st == 0) begin
        if (bus.tx_req) begin
          cur_word = bus.tx_data;
          rx_log.push_back(cur_word);
          if (exp_q.size() == 0) chk("tx_word_unexpected", 1, 0);
          else                   chk("tx_word", cur_word, exp_q.pop_front());
          tx_cnt = tx_delay;
          tx_st  = 1;
        end
      end else if (tx_st == 1) begin
        chk("req_held_until_busy", bus.tx_req, 1);
        chk("data_stable_req", bus.tx_data, cur_word);
        tx_cnt--;
        if (tx_cnt == 0) begin
          bus.tx_busy = 1'b1;
          tx_cnt      = 32;
          tx_st       = 2;
        end
      end else begin
        chk("req_low_while_busy", bus.tx_req, 0);
        chk("data_stable_busy", bus.tx_data, cur_word);
        tx_cnt--;
        if (tx_cnt == 0) begin
          bus.tx_busy = 1'b0;
          tx_st       = 0;
        end
      end
      fb_d = bus.frame_busy;
    end
  end

  task automatic pulse_start();
    @(negedge ck) bus.start = 1'b1;
    @(negedge ck) bus.start = 1'b0;
  endtask

  task automatic wait_started(input int target, input int budget, input string nm);
    int k = 0;
    while (frames_started < target && k < budget) begin @(negedge ck); k++; end
    chk(nm, frames_started >= target, 1);
  endtask

  task automatic wait_done(input int target, input int budget, input string nm);
    int k = 0;
    while (frames_done < target && k < budget) begin @(negedge ck); k++; end
    chk(nm, frames_done >= target, 1);
  endtask

  task automatic wait_led(input int target, input int budget, input string nm);
    int k = 0;
    while (led_cnt < target && k < budget) begin @(negedge ck); k++; end
    chk(nm, led_cnt >= target, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_ram_re", bus.ram_re, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_tx_req", bus.tx_req, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_frame_busy", bus.frame_busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
  endtask

  initial begin : main
    int base, based, kx;
    bus.enable = 1'b0; bus.start = 1'b0; bus.brightness = 5'h00;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge ck);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (20) @(negedge ck);
    chk("idle_after_reset", frames_started, 0);

    // Single frame with known contents.
    mem[0] = 24'h0000FF; mem[1] = 24'h00FF00; mem[2] = 24'hFF0000;
    bus.brightness = 5'h04; tx_delay = 1; rx_log.delete();
    pulse_start();
    wait_done(1, 2000, "single_frame_done");
    chk("single_word_count", rx_log.size(), 6);
    for (int i = 0; i < 6 && i < rx_log.size(); i++) chk("single_word_literal", rx_log[i], lit[i]);
    chk("single_frame_len_ok", (done_cyc - rise_cyc) <= 40 * (1 + N_LEDS + END_WORDS), 1);
    repeat (30) @(negedge ck);
    chk("single_one_frame", frames_done, 1);

    // Three requests during a frame give exactly one back-to-back extra frame.
    base = frames_started; based = frames_done;
    pulse_start();
    wait_started(base + 1, 10, "pend_first_start");
    repeat (20) @(negedge ck); pulse_start();
    repeat (7)  @(negedge ck); pulse_start();
    repeat (3)  @(negedge ck); pulse_start();
    wait_done(based + 2, 3000, "pend_frames_done");
    repeat (60) @(negedge ck);
    chk("pend_frame_count", frames_started - base, 2);
    chk("pend_no_gap", rise_gap, 1);

    // Brightness changed during LED word 1 only affects the following frame.
    bus.brightness = 5'h1F; rx_log.delete(); based = frames_done;
    pulse_start();
    wait_led(2, 500, "bri_reach_led1");
    bus.brightness = 5'h01;
    wait_done(based + 1, 2000, "bri_frame1_done");
    for (int i = 1; i <= N_LEDS && i < rx_log.size(); i++) chk("bri_hdr_old", rx_log[i][31:24], 8'hFF);
    rx_log.delete();
    pulse_start();
    wait_done(based + 2, 2000, "bri_frame2_done");
    if (rx_log.size() > 1) chk("bri_hdr_new", rx_log[1][31:24], 8'hE1);
    else                   chk("bri_frame2_words", rx_log.size(), 6);

    // Slow shifter: busy rises five cycles after the request.
    for (int i = 0; i < N_LEDS; i++) mem[i] = 24'($urandom);
    tx_delay = 5; based = frames_done;
    pulse_start();
    wait_done(based + 1, 3000, "slow_tx_done");

    // Randomized frames, shifter latency, brightness changes and extra requests.
    for (int it = 0; it < 6; it++) begin
      repeat (10) @(negedge ck);
      for (int i = 0; i < N_LEDS; i++) mem[i] = 24'($urandom);
      bus.brightness = 5'($urandom);
      tx_delay = $urandom_range(1, 6);
      kx = $urandom_range(0, 2);
      base = frames_started; based = frames_done;
      pulse_start();
      wait_started(base + 1, 10, "rand_start");
      for (int j = 0; j < kx; j++) begin
        repeat ($urandom_range(5, 40)) @(negedge ck);
        bus.brightness = 5'($urandom);
        pulse_start();
      end
      wait_done(based + 1 + ((kx > 0) ? 1 : 0), 6000, "rand_done");
      repeat (20) @(negedge ck);
      chk("rand_frame_count", frames_started - base, 1 + ((kx > 0) ? 1 : 0));
    end

    // Auto-refresh from reset, then stop by dropping enable mid-frame.
    tx_delay = 1;
    @(negedge ck) rst_n = 1'b0;
    bus.enable = 1'b1;
    repeat (2) @(negedge ck);
    rst_n = 1'b1;
    base = frames_started;
    wait_started(base + 1, 4, "auto_first_immediate");
    for (int k = 2; k <= 4; k++) begin
      wait_started(base + k, 2000, "auto_next_start");
      chk("auto_gap_16", (rise_gap >= GAP_CYCLES) && (rise_gap <= GAP_CYCLES + 1), 1);
    end
    repeat (10) @(negedge ck);
    bus.enable = 1'b0;
    based = frames_done;
    wait_done(based + 1, 2000, "auto_last_done");
    repeat (80) @(negedge ck);
    chk("auto_stopped", frames_started - base, 4);

    // Asynchronous reset during LED word 2.
    base = frames_started;
    pulse_start();
    wait_led(3, 500, "midrst_reach_led2");
    repeat (3) @(negedge ck);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge ck);
    rst_n = 1'b1;
    repeat (100) @(negedge ck);
    chk("midrst_stays_idle", frames_started - base, 1);
    chk("midrst_busy_low", bus.frame_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    n_bad++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "bench timeout");
  end
endmodule
`default_nettype wire

// File: doc/led_frame_sched.md
# led_frame_sched

Frame sequencer for an SK9822 LED string. It sits between the LED colour dual-port RAM (24-bit words, 1-cycle read latency) and the 32-bit serial `tx` shifter. Each frame it emits the start word, then one header+colour word per LED read from RAM, then the end words. Frames run either on a single request or on a periodic auto-refresh, and a global brightness is applied to every LED word.

## Interface

Parameters:
- `N_LEDS`, 12: LEDs in the string, i.e. RAM words read per frame (1..2^ADDR_W).
- `ADDR_W`, 4: RAM address width.
- `END_WORDS`, 1: number of 32'hFFFF_FFFF end words (≥1).
- `GAP_CYCLES`, 4096: idle cycles between auto-refresh frames (≥1).

Ports:
- `ck` in 1: system clock. This is the single clock; RAM and `tx` run on it.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: auto-refresh mode while high.
- `start` in 1: one-cycle frame request.
- `brightness` in 5: global brightness field.
- `ram_re` out 1: RAM read strobe.
- `ram_addr` out ADDR_W: RAM read address.
- `ram_data` in 24: RAM read data, valid the cycle after `ram_re`.
- `tx_req` out 1: word-valid request to `tx` (drives its `tx` input).
- `tx_data` out 32: word to send.
- `tx_busy` in 1: `tx` shifting.
- `frame_busy` out 1: high from frame start to frame end.
- `frame_done` out 1: one-cycle pulse at the end of each frame.

## Operation

- States: IDLE, START_W, FETCH, CAPTURE, ISSUE, DRAIN, END_W.
- IDLE: starts a frame when `pend`, `start`, or (`enable` && gap counter == 0) is true.
  - On frame start: latch `brightness` into `bri_q` (held for the whole frame), clear `idx`, clear `pend`, set `frame_busy`, go to START_W.
- START_W: `tx_data` ← 32'h0000_0000, then go to ISSUE.
- FETCH: `ram_re`=1 and `ram_addr`=`idx` for exactly one cycle, then go to CAPTURE.
- CAPTURE: `tx_data` ← {3'b111, `bri_q`, `ram_data`}, with `ram_data` passed verbatim. Then go to ISSUE.
- ISSUE: hold `tx_req`=1 until `tx_busy` is sampled high, deassert it that edge, then go to DRAIN.
- DRAIN: wait for `tx_busy` to be sampled low, then choose the next word:
  - after the start word → FETCH;
  - after LED word `idx` < N_LEDS-1 → `idx`+1, FETCH;
  - after the last LED word → END_W with `end_cnt`=0;
  - after an end word with `end_cnt` < END_WORDS-1 → `end_cnt`+1, END_W;
  - otherwise the frame is over: `frame_done` pulses, `frame_busy` clears, gap counter loads GAP_CYCLES-1, go to IDLE.
- END_W: `tx_data` ← 32'hFFFF_FFFF, then go to ISSUE.
- Gap counter: decrements in IDLE down to 0 and saturates there. Reset value is 0, so with `enable` high the first frame starts immediately out of reset.
- `start` while `frame_busy`=1 sets `pend` (one deep; further pulses are absorbed). A pending frame starts on the first IDLE cycle and ignores the gap.
- `enable` falling mid-frame: the current frame completes and no new auto frame starts.
- `brightness` changes mid-frame take effect next frame only.
- `idx` never exceeds N_LEDS-1; `ram_addr` is 0 outside FETCH.

## Timing

- Reset values: `ram_re`=0, `ram_addr`=0, `tx_req`=0, `tx_data`=0, `frame_busy`=0, `frame_done`=0, state=IDLE, `pend`=0, gap=0.
- Reset asserted mid-frame: all of the above apply immediately and asynchronously. The in-flight `tx` word is abandoned.
- All outputs are registered.
- Frame start: `frame_busy` rises the edge after the trigger is sampled in IDLE.
- Per LED word, excluding shifter time: 1 cycle FETCH + 1 cycle CAPTURE + ISSUE (≥1 cycle) + DRAIN.
  - `tx_data` is stable from ISSUE entry until DRAIN exits.
- With a same-clock `tx` (busy rises 1 cycle after sampling `tx_req`, falls after 32 shift cycles), each word costs ≤ 40 cycles.
  - Frame length ≤ 40·(1+N_LEDS+END_WORDS) cycles.
- `tx_req` is never high while `tx_busy` is high in DRAIN; only one word is in flight at a time.
- `frame_done` and `frame_busy` falling occur on the same edge.
- A `start` arriving that same cycle is treated as a new request: it is taken in IDLE the next cycle.

## Test plan

- Single frame: N_LEDS=3, END_WORDS=1, RAM = {0x0000FF, 0x00FF00, 0xFF0000}, `brightness`=5'h04, pulse `start` → `tx` receives 0x00000000, 0xE40000FF, 0xE400FF00, 0xE4FF0000, 0xFFFFFFFF in order; exactly one `frame_done` pulse; `ram_addr` sequence 0,1,2.
- Auto-refresh: `enable`=1, GAP_CYCLES=16 → first frame starts right after reset; each next `frame_busy` rise is exactly 16 IDLE cycles after the previous `frame_done` (±1 for the trigger edge). Drop `enable` mid-frame → that frame completes and no further frames follow.
- Pending request: pulse `start` three times during a frame → exactly one extra frame, starting on the first IDLE cycle with no gap.
- Brightness latch: change `brightness` from 5'h1F to 5'h01 during LED word 1 → all LED words of that frame carry 0xFF header; next frame carries 0xE1.
- Slow `tx`: model `tx_busy` rising 5 cycles after `tx_req` → `tx_req` stays high those 5 cycles, no word is skipped or duplicated, and `tx_data` does not change while requested or busy.
- Reset mid-frame: assert `rst_n`=0 during LED word 2 → all outputs take their reset values at once; after release with `enable`=0 and no `start`, it stays IDLE.
